// File: rtl/multi_battery_monitor_pkg.sv
// Shared types, defaults and the quartile-to-LED decode for the battery monitor.
package multi_battery_monitor_pkg;

  localparam int unsigned DefNBatt   = 2;
  localparam int unsigned DefWidth   = 4;
  localparam int unsigned DefEmptyTh = 2;
  localparam int unsigned DefDebounce = 4;
  localparam int unsigned DefBlinkDiv = 8;

  // Charge quartile of the summed battery level.
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quartile_e;

  // One-hot active-low LED pattern: bit q low, the rest high.
  function automatic logic [3:0] quartileToLedN(input quartile_e q);
    return ~(4'b0001 << q);
  endfunction

endpackage

// File: rtl/multi_battery_monitor_channel_empty_debounce.sv
// Per-channel low-level debounce: declares a channel empty after DEBOUNCE
// consecutive low samples and releases it on the first non-low sample.
module channel_empty_debounce #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned EMPTY_TH = 2,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] level,
  output logic             empty_n,
  // Value empty_n takes on the next edge (ignoring reset); lets the top
  // start the alarm on the same edge the flag drops.
  output logic             emptyNextN
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DebMax = CW'(DEBOUNCE);

  logic [CW-1:0] cntQ, cntD;
  logic          isLow;

  assign isLow = 32'(level) < EMPTY_TH;

  // Next-state for the saturating low counter and the empty flag.
  always_comb begin
    cntD       = cntQ;
    emptyNextN = empty_n;
    if (sample_valid) begin
      if (isLow) begin
        cntD       = (cntQ == DebMax) ? cntQ : cntQ + CW'(1);
        emptyNextN = (cntD != DebMax);
      end else begin
        cntD       = '0;
        emptyNextN = 1'b1;
      end
    end
  end

  // Counter and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cntQ    <= '0;
      empty_n <= 1'b1;
    end else begin
      cntQ    <= cntD;
      empty_n <= emptyNextN;
    end
  end

endmodule

// File: rtl/multi_battery_monitor.sv
// Multi-channel battery monitor: sums the channel levels, shows the charge
// quartile on active-low LEDs, debounces per-channel empty flags and blinks
// an active-low alarm while any channel is empty.
module multi_battery_monitor
  import multi_battery_monitor_pkg::*;
#(
  parameter int unsigned N_BATT    = DefNBatt,
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned EMPTY_TH  = DefEmptyTh,
  parameter int unsigned DEBOUNCE  = DefDebounce,
  parameter int unsigned BLINK_DIV = DefBlinkDiv
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sample_valid,
  input  logic [N_BATT*WIDTH-1:0]         batt,
  output logic [WIDTH+$clog2(N_BATT):0]   total,
  output logic [N_BATT-1:0]               empty_n,
  output logic [3:0]                      led_state_n,
  output logic                            alarm_n
);

  localparam int unsigned TW = WIDTH + $clog2(N_BATT) + 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  // Thresholds are compared against 4*sum; TW+2 bits hold 4*sum and 3*MAX.
  localparam logic [TW+1:0] Max1 =
      (TW+2)'(N_BATT) * ((((TW+2)'(1)) << WIDTH) - (TW+2)'(1));
  localparam logic [TW+1:0] Max2 = Max1 * (TW+2)'(2);
  localparam logic [TW+1:0] Max3 = Max1 * (TW+2)'(3);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_DIV - 1);

  logic [TW-1:0]     sumD;
  logic [TW+1:0]     sum4;
  quartile_e         qD, qQ;
  logic              seenQ;
  logic [N_BATT-1:0] emptyNextN;
  logic              anyEmptyD, anyEmptyQ;
  logic [BW-1:0]     blinkQ;

  // Per-channel debounce instances.
  for (genvar g = 0; g < N_BATT; g++) begin : gen_chan
    channel_empty_debounce #(
      .WIDTH   (WIDTH),
      .EMPTY_TH(EMPTY_TH),
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clk         (clk),
      .rst         (rst),
      .sample_valid(sample_valid),
      .level       (batt[g*WIDTH +: WIDTH]),
      .empty_n     (empty_n[g]),
      .emptyNextN  (emptyNextN[g])
    );
  end

  // Sum of all channels and its quartile.
  always_comb begin
    sumD = '0;
    for (int unsigned i = 0; i < N_BATT; i++) begin
      sumD = sumD + TW'(batt[i*WIDTH +: WIDTH]);
    end
    sum4 = {sumD, 2'b00};
    if (sum4 < Max1)      qD = Q0;
    else if (sum4 < Max2) qD = Q1;
    else if (sum4 < Max3) qD = Q2;
    else                  qD = Q3;
  end

  assign anyEmptyD = ~&emptyNextN;
  assign anyEmptyQ = ~&empty_n;

  // LEDs stay dark until the first accepted sample.
  assign led_state_n = seenQ ? quartileToLedN(qQ) : 4'b1111;

  // Total, quartile and seen-sample registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      total <= '0;
      qQ    <= Q0;
      seenQ <= 1'b0;
    end else if (sample_valid) begin
      total <= sumD;
      qQ    <= qD;
      seenQ <= 1'b1;
    end
  end

  // Blink counter and alarm; the alarm starts low on the edge an empty flag drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      blinkQ  <= '0;
      alarm_n <= 1'b1;
    end else if (!anyEmptyD) begin
      blinkQ  <= '0;
      alarm_n <= 1'b1;
    end else if (!anyEmptyQ) begin
      blinkQ  <= '0;
      alarm_n <= 1'b0;
    end else if (blinkQ == BlinkLast) begin
      blinkQ  <= '0;
      alarm_n <= ~alarm_n;
    end else begin
      blinkQ  <= blinkQ + BW'(1);
    end
  end

endmodule

// File: tb/tb_multi_battery_monitor.sv
// Directed self-checking bench for multi_battery_monitor (default and wide instances).
module tb_multi_battery_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sv = 1'b0;
  logic [7:0] batt = '0;
  logic [5:0] total;
  logic [1:0] empty_n;
  logic [3:0] led_n;
  logic       alarm_n;

  logic        rstW = 1'b0;
  logic        svW = 1'b0;
  logic [23:0] battW = '0;
  logic [10:0] totalW;
  logic [2:0]  emptyW;
  logic [3:0]  ledW;
  logic        alarmW;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  multi_battery_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sv),
    .batt        (batt),
    .total       (total),
    .empty_n     (empty_n),
    .led_state_n (led_n),
    .alarm_n     (alarm_n)
  );

  multi_battery_monitor #(
    .N_BATT(3),
    .WIDTH (8)
  ) dutW (
    .clk         (clk),
    .rst         (rstW),
    .sample_valid(svW),
    .batt        (battW),
    .total       (totalW),
    .empty_n     (emptyW),
    .led_state_n (ledW),
    .alarm_n     (alarmW)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One accepted sample; ch1 is the upper nibble.
  task automatic sample(input logic [3:0] ch1, input logic [3:0] ch0);
    batt = {ch1, ch0};
    sv = 1'b1;
    tick();
    sv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sv = 1'b1;
    batt = 8'hFF;
    tick();
    rst = 1'b0;
    sv = 1'b0;
    totalCnt++;
    if (total !== 6'd0) $display("FAIL reset_total: got %0d want 0", total);
    else passCnt++;
    totalCnt++;
    if (empty_n !== 2'b11) $display("FAIL reset_empty: got %b want 11", empty_n);
    else passCnt++;
    totalCnt++;
    if (led_n !== 4'b1111) $display("FAIL reset_led: got %b want 1111", led_n);
    else passCnt++;
    totalCnt++;
    if (alarm_n !== 1'b1) $display("FAIL reset_alarm: got %b want 1", alarm_n);
    else passCnt++;
  endtask

  task automatic test_first_sample();
    sample(4'd3, 4'd4);
    totalCnt++;
    if (total !== 6'd7) $display("FAIL first_total: got %0d want 7", total);
    else passCnt++;
    totalCnt++;
    if (led_n !== 4'b1110) $display("FAIL first_led: got %b want 1110", led_n);
    else passCnt++;
    totalCnt++;
    if (empty_n !== 2'b11 || alarm_n !== 1'b1)
      $display("FAIL first_flags: got empty %b alarm %b want 11 1", empty_n, alarm_n);
    else passCnt++;
  endtask

  task automatic test_quartiles();
    logic [3:0] c1 [6] = '{4'd4, 4'd7, 4'd7, 4'd11, 4'd11, 4'd15};
    logic [3:0] c0 [6] = '{4'd4, 4'd7, 4'd8, 4'd11, 4'd12, 4'd15};
    logic [5:0] expT [6] = '{6'd8, 6'd14, 6'd15, 6'd22, 6'd23, 6'd30};
    logic [3:0] expL [6] = '{4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
    for (int i = 0; i < 6; i++) begin
      sample(c1[i], c0[i]);
      totalCnt++;
      if (total !== expT[i] || led_n !== expL[i])
        $display("FAIL quartile_%0d: got total %0d led %b want %0d %b",
                 i, total, led_n, expT[i], expL[i]);
      else passCnt++;
    end
    // Idle cycle with changed input must hold.
    batt = 8'h00;
    tick();
    totalCnt++;
    if (total !== 6'd30 || led_n !== 4'b0111)
      $display("FAIL idle_hold: got total %0d led %b want 30 0111", total, led_n);
    else passCnt++;
  endtask

  task automatic test_boundaries();
    do_reset();
    sample(4'd0, 4'd0);
    totalCnt++;
    if (total !== 6'd0 || led_n !== 4'b1110)
      $display("FAIL all_zero: got total %0d led %b want 0 1110", total, led_n);
    else passCnt++;
    for (int i = 0; i < 4; i++) sample(4'd2, 4'd2);
    totalCnt++;
    if (empty_n !== 2'b11 || alarm_n !== 1'b1)
      $display("FAIL level_eq_th: got empty %b alarm %b want 11 1", empty_n, alarm_n);
    else passCnt++;
  endtask

  task automatic test_debounce_alarm();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      sample(4'd5, 4'd1);
      tick();
      tick();
      totalCnt++;
      if (empty_n !== 2'b11 || alarm_n !== 1'b1)
        $display("FAIL deb_early_%0d: got empty %b alarm %b want 11 1", i, empty_n, alarm_n);
      else passCnt++;
    end
    sample(4'd5, 4'd1);
    totalCnt++;
    if (empty_n !== 2'b10 || alarm_n !== 1'b0)
      $display("FAIL deb_assert: got empty %b alarm %b want 10 0", empty_n, alarm_n);
    else passCnt++;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 7 || k == 8 || k == 15 || k == 16) begin
        totalCnt++;
        if (alarm_n !== ((k == 8 || k == 15) ? 1'b1 : 1'b0))
          $display("FAIL blink_k%0d: got %b want %b", k, alarm_n,
                   (k == 8 || k == 15) ? 1'b1 : 1'b0);
        else passCnt++;
      end
    end
    sample(4'd5, 4'd2);
    totalCnt++;
    if (empty_n !== 2'b11 || alarm_n !== 1'b1)
      $display("FAIL deb_release: got empty %b alarm %b want 11 1", empty_n, alarm_n);
    else passCnt++;
  endtask

  task automatic test_debounce_interrupted();
    logic ok;
    do_reset();
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sample((i == 3) ? 4'd5 : 4'd0, 4'd5);
      if (empty_n[1] !== 1'b1) ok = 1'b0;
    end
    totalCnt++;
    if (!ok || alarm_n !== 1'b1)
      $display("FAIL deb_interrupt: got ok %b empty %b want 1 11", ok, empty_n);
    else passCnt++;
  endtask

  task automatic test_reset_mid_blink();
    do_reset();
    for (int i = 0; i < 4; i++) sample(4'd5, 4'd1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    sv = 1'b1;
    batt = {4'd5, 4'd1};
    tick();
    rst = 1'b0;
    sv = 1'b0;
    totalCnt++;
    if (total !== 6'd0 || empty_n !== 2'b11 || led_n !== 4'b1111 || alarm_n !== 1'b1)
      $display("FAIL rst_blink: got total %0d empty %b led %b alarm %b want 0 11 1111 1",
               total, empty_n, led_n, alarm_n);
    else passCnt++;
    for (int i = 0; i < 3; i++) sample(4'd5, 4'd1);
    totalCnt++;
    if (empty_n !== 2'b11) $display("FAIL rst_deb_3: got %b want 11", empty_n);
    else passCnt++;
    sample(4'd5, 4'd1);
    totalCnt++;
    if (empty_n !== 2'b10 || alarm_n !== 1'b0)
      $display("FAIL rst_deb_4: got empty %b alarm %b want 10 0", empty_n, alarm_n);
    else passCnt++;
    for (int k = 0; k < 8; k++) tick();
    totalCnt++;
    if (alarm_n !== 1'b1) $display("FAIL rst_blink_restart: got %b want 1", alarm_n);
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    sv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      batt = {4'(i + 2), 4'd1};
      tick();
      totalCnt++;
      if (total !== 6'(i + 3) || empty_n !== ((i == 3) ? 2'b10 : 2'b11))
        $display("FAIL b2b_%0d: got total %0d empty %b want %0d %b", i, total, empty_n,
                 i + 3, (i == 3) ? 2'b10 : 2'b11);
      else passCnt++;
    end
    sv = 1'b0;
  endtask

  task automatic test_wide();
    rstW = 1'b1;
    tick();
    rstW = 1'b0;
    battW = {8'd255, 8'd255, 8'd255};
    svW = 1'b1;
    tick();
    svW = 1'b0;
    totalCnt++;
    if (totalW !== 11'd765 || ledW !== 4'b0111)
      $display("FAIL wide_full: got total %0d led %b want 765 0111", totalW, ledW);
    else passCnt++;
    totalCnt++;
    if (emptyW !== 3'b111 || alarmW !== 1'b1)
      $display("FAIL wide_flags: got empty %b alarm %b want 111 1", emptyW, alarmW);
    else passCnt++;
  endtask

  initial begin
    tick();
    test_reset();
    test_first_sample();
    test_quartiles();
    test_boundaries();
    test_debounce_alarm();
    test_debounce_interrupted();
    test_reset_mid_blink();
    test_back_to_back();
    test_wide();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/multi_battery_monitor.md
MULTI_BATTERY_MONITOR -- requirements
Module: multi_battery_monitor

Interface
REQ-001 Parameter N_BATT, default 2: number of battery channels, minimum 1.
REQ-002 Parameter WIDTH, default 4: bits per battery level, minimum 2.
REQ-003 Parameter EMPTY_TH, default 2: a level strictly below this value counts as low.
REQ-004 Parameter DEBOUNCE, default 4: consecutive low samples needed to declare a channel empty, minimum 1.
REQ-005 Parameter BLINK_DIV, default 8: alarm toggle period in clock cycles, minimum 1.
REQ-006 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port sample_valid, input, 1: batt holds a new sample this cycle.
REQ-009 Port batt, input, N_BATT*WIDTH: packed levels; channel i is bits [i*WIDTH +: WIDTH].
REQ-010 Port total, output, WIDTH+clog2(N_BATT)+1: registered sum of the last accepted sample.
REQ-011 Port empty_n, output, N_BATT: per-channel empty indicator, active-low (FPGA LED).
REQ-012 Port led_state_n, output, 4: one-hot charge quartile, active-low.
REQ-013 Port alarm_n, output, 1: blinking any-empty alarm, active-low.

Function
REQ-014 On the edge where sample_valid=1, total SHALL load the unsigned sum of all channels; total is visible the next cycle (latency 1), with no overflow by construction.
REQ-015 MAX SHALL equal N_BATT*(2^WIDTH-1). Quartile q SHALL be computed from the new sum on that same edge: q=0 if 4*sum<MAX, q=1 if 4*sum<2*MAX, q=2 if 4*sum<3*MAX, else q=3.
REQ-016 led_state_n SHALL drive bit q low and all other bits high, but only after the first accepted sample; before that, all four bits SHALL be high.
REQ-017 Each channel SHALL keep a saturating low-counter: on an accepted sample it increments (saturating at DEBOUNCE) if level<EMPTY_TH, and clears to 0 otherwise.
REQ-018 empty_n[i] SHALL go low on the edge where the channel's counter reaches DEBOUNCE, and high on the edge of the first accepted sample with level>=EMPTY_TH.
REQ-019 While sample_valid=0, the low-counters, total, q and empty_n SHALL hold their values.
REQ-020 any_empty is the OR of all empty flags. While any_empty=1, a blink counter SHALL count 0..BLINK_DIV-1 and wrap, and alarm_n SHALL toggle on each wrap.
REQ-021 When the alarm becomes active, alarm_n SHALL go low on the same edge empty_n first goes low, and the blink counter SHALL start from 0.
REQ-022 While any_empty=0, alarm_n SHALL be 1 and the blink counter SHALL be 0.
REQ-023 Boundaries:
- level=EMPTY_TH is not low;
- all channels at 2^WIDTH-1 gives q=3, total=MAX;
- all channels at 0 gives q=0, total=0;
- sample_valid held high for consecutive cycles accepts every cycle.

Reset
REQ-024 When rst=1 on an edge, the following SHALL be set on that edge, overriding sample_valid:
- total=0;
- all low-counters=0;
- empty_n all 1;
- led_state_n=4'b1111;
- seen-sample flag=0;
- blink counter=0;
- alarm_n=1.
REQ-025 Reset asserted mid-debounce or mid-blink SHALL discard all progress. The first accepted sample after reset is treated like the first sample ever.

Structure
REQ-026 A shared package SHALL hold the quartile typedef (2 bits, Q0..Q3), the decode function from quartile to the one-hot active-low LED pattern, and the default parameter constants.
REQ-027 Per-channel debounce SHALL be a sub-module, channel_empty_debounce, instantiated N_BATT times through a generate loop. Summation, quartile, alarm and blink logic SHALL stay in the top module.

Verification
REQ-028 Defaults; reset, then one sample batt={4'd3,4'd4} -> next cycle total=7, led_state_n=4'b1110, empty_n=2'b11, alarm_n=1.
REQ-029 Defaults; samples with totals 8, 14, 15, 22, 23, 30 -> led_state_n = 1101, 1101, 1011, 1011, 0111, 0111 in that order.
REQ-030 Defaults; channel 0 held at level 1 for 4 accepted samples, with idle cycles between samples:
- empty_n[0] goes low only on the 4th sample;
- alarm_n goes low on that same edge, then toggles every 8 cycles;
- a level-2 sample releases empty_n[0] and sets alarm_n=1.
REQ-031 Defaults; channel 1 at level 0 for 3 samples, then level 5, then level 0 for 3 samples -> empty_n[1] stays 1 throughout.
REQ-032 Defaults; rst pulsed during blinking -> next cycle all outputs equal their reset values; a level-1 sample then needs 4 more samples to reassert empty.
REQ-033 Parameter sweep N_BATT=3, WIDTH=8, all channels at 255 -> total=765, led_state_n=4'b0111.
